// File: rtl/demosaic_root_mul_pipe.sv
// Elastic multiply pipeline: per-beat signed/unsigned product, optional rounding
// right-shift and saturation to DOUT_WIDTH, with valid/ready flow control.
module demosaic_root_mul_pipe #(
  parameter int DIN0_WIDTH = 18,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 25,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int CW = (PW + 2 > DOUT_WIDTH + 2) ? PW + 2 : DOUT_WIDTH + 2;
  localparam int RB = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [CW-1:0] RND  = (SHIFT > 0) ? (CW'(1) << RB) : CW'(0);
  localparam logic signed [CW-1:0] UMAX = (CW'(1) << DOUT_WIDTH) - CW'(1);
  localparam logic signed [CW-1:0] SMAX = (CW'(1) << (DOUT_WIDTH - 1)) - CW'(1);
  localparam logic signed [CW-1:0] SMIN = -(CW'(1) << (DOUT_WIDTH - 1));

  // Round half-up then arithmetic shift; unsigned values are never negative here.
  function automatic logic signed [CW-1:0] round_shift(input logic signed [CW-1:0] v);
    logic signed [CW-1:0] r;
    r = v;
    if (SHIFT > 0) r = (v + RND) >>> SHIFT;
    return r;
  endfunction

  // Returns {clamped, value} for the requested signedness.
  function automatic logic [DOUT_WIDTH:0] saturate(input logic signed [CW-1:0] v,
                                                   input logic sgn);
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    logic [DOUT_WIDTH:0]  res;
    hi  = sgn ? SMAX : UMAX;
    lo  = sgn ? SMIN : CW'(0);
    res = {1'b0, v[DOUT_WIDTH-1:0]};
    if (v > hi)      res = {1'b1, hi[DOUT_WIDTH-1:0]};
    else if (v < lo) res = {1'b1, lo[DOUT_WIDTH-1:0]};
    return res;
  endfunction

  logic signed [DIN0_WIDTH:0] a_x;
  logic signed [DIN1_WIDTH:0] b_x;
  logic signed [PW:0]         prod_c;

  logic signed [PW:0]         prod_p [NUM_STAGE];
  logic                       sgn_p  [NUM_STAGE];
  logic [NUM_STAGE-1:0]       vld_p;
  logic [NUM_STAGE-1:0]       adv;

  logic signed [CW-1:0]       ext_c;
  logic [DOUT_WIDTH:0]        res_c;

  always_comb begin
    a_x    = {in_signed & din0[DIN0_WIDTH-1], din0};
    b_x    = {in_signed & din1[DIN1_WIDTH-1], din1};
    prod_c = (PW+1)'(a_x) * (PW+1)'(b_x);
  end

  // A stage may advance unless it and every stage after it are full and the sink stalls.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      full   = full & vld_p[k];
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready = adv[0] & ap_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p <= '0;
    end else begin
      if (adv[0]) vld_p[0] <= in_valid;
      for (int k = 1; k < NUM_STAGE; k++)
        if (adv[k]) vld_p[k] <= vld_p[k-1];
    end
  end

  // Stage 0 captures the full product; later stages only carry it forward.
  always_ff @(posedge ap_clk) begin
    if (adv[0] && in_valid) begin
      prod_p[0] <= prod_c;
      sgn_p[0]  <= in_signed;
    end
    for (int k = 1; k < NUM_STAGE; k++) begin
      if (adv[k] && vld_p[k-1]) begin
        prod_p[k] <= prod_p[k-1];
        sgn_p[k]  <= sgn_p[k-1];
      end
    end
  end

  // Output stage: rounding and clamping from the held last-stage register.
  always_comb begin
    ext_c     = CW'(prod_p[NUM_STAGE-1]);
    res_c     = saturate(round_shift(ext_c), sgn_p[NUM_STAGE-1]);
    out_valid = vld_p[NUM_STAGE-1];
    dout      = out_valid ? res_c[DOUT_WIDTH-1:0] : '0;
    out_sat   = out_valid & res_c[DOUT_WIDTH];
  end

endmodule

// File: doc/demosaic_root_mul_pipe.md
DEMOSAIC_ROOT_MUL_PIPE -- requirements
Module: demosaic_root_mul_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 18, width of operand 0 (2..32).
REQ-002 SHALL have parameter DIN1_WIDTH, default 8, width of operand 1 (2..32).
REQ-003 SHALL have parameter DOUT_WIDTH, default 25, result width (2..64).
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth in registers (1..4).
REQ-005 SHALL have parameter SHIFT, default 0, right-shift with rounding applied to the product (0..DIN0_WIDTH+DIN1_WIDTH-1).
REQ-006 SHALL have port ap_clk, input, 1, sole clock; all registers rising-edge.
REQ-007 SHALL have port ap_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, operand beat valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts a beat.
REQ-010 SHALL have port in_signed, input, 1, per-beat mode: 1 = two's-complement, 0 = unsigned.
REQ-011 SHALL have port din0, input, DIN0_WIDTH, operand 0.
REQ-012 SHALL have port din1, input, DIN1_WIDTH, operand 1.
REQ-013 SHALL have port out_valid, output, 1, result beat valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-015 SHALL have port dout, output, DOUT_WIDTH, result.
REQ-016 SHALL have port out_sat, output, 1, result was clamped.

Function
REQ-017 SHALL accept a beat when in_valid && in_ready at a rising edge; SHALL emit one when out_valid && out_ready.
REQ-018 SHALL form full product P = din0*din1 at width DIN0_WIDTH+DIN1_WIDTH, both operands sign-extended when in_signed=1, zero-extended otherwise.
REQ-019 SHALL, when SHIFT>0, add 2^(SHIFT-1) to P then shift right arithmetically (signed) or logically (unsigned); SHIFT=0 SHALL pass P unchanged.
REQ-020 SHALL saturate the shifted value to DOUT_WIDTH: unsigned clamp to 2^DOUT_WIDTH-1; signed clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; out_sat=1 iff clamping occurred.
REQ-021 SHALL carry in_signed alongside its data through every stage; mixed-mode back-to-back beats SHALL each use their own mode.
REQ-022 SHALL have latency exactly NUM_STAGE cycles from acceptance to out_valid when unstalled; throughput one beat per cycle.
REQ-023 SHALL implement an elastic pipeline: stage k advances when stage k empty or stage k+1 advances; last stage advances when empty or out_ready=1.
REQ-024 SHALL drive in_ready = stage 0 can advance; in_ready SHALL be combinational from out_ready and stage valids only, never from in_valid.
REQ-025 SHALL collapse bubbles: with out_ready held 0, exactly NUM_STAGE beats are accepted before in_ready=0.
REQ-026 SHALL hold dout, out_sat, out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL never drop, duplicate or reorder beats; simultaneous accept and emit in one cycle SHALL be supported at full occupancy.
REQ-028 SHALL ignore din0/din1/in_signed when in_valid=0; invalid stages' data registers are don't-care.

Reset
REQ-029 SHALL clear all stage valid bits asynchronously on ap_rst_n=0; out_valid=0, out_sat=0, dout=0 during and after reset.
REQ-030 SHALL hold in_ready=0 while ap_rst_n=0 and SHALL drive it 1 in the first cycle after release.
REQ-031 SHALL discard all in-flight beats on reset mid-operation; no result from before reset SHALL appear afterwards.

Verification
REQ-032 Defaults, unsigned, 1000*200, out_ready=1 -> dout=200000, out_sat=0, out_valid exactly 3 cycles after acceptance.
REQ-033 Defaults, unsigned 262143*255 -> dout=33554431, out_sat=1; signed din0=18'h20000, din1=8'h80 (+16777216) -> dout=16777215, out_sat=1.
REQ-034 SHIFT=4: unsigned 100*3 -> dout=19; signed -100*3 -> dout=-19 (two's complement), out_sat=0 both.
REQ-035 Stream 20 random beats, out_ready held 0 for cycles 5-12 -> in_ready drops after 3 pending beats, all 20 results in order, matching reference model, dout stable while stalled.
REQ-036 Assert ap_rst_n=0 with 3 beats in flight -> out_valid=0 immediately, in_ready=0; after release first output is from first post-reset beat.
REQ-037 Sweep NUM_STAGE=1..4 with alternating in_signed per beat and random out_ready -> latency equals NUM_STAGE when unstalled, no loss or duplication.
